// File: rtl/multi_blinker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multi_blinker_if                                             |
// | Description : Configuration port of multi_blinker. The host (master)       |
// |               presents one channel configuration per valid/ready transfer; |
// |               the blinker (slave) answers with ready and an error pulse    |
// |               for channel indices it does not implement.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Signals                                                                    |
// |   cfg_valid   host -> blinker  configuration request                       |
// |   cfg_ready   blinker -> host  configuration accept                        |
// |   cfg_ch      host -> blinker  target channel index                        |
// |   cfg_mode    host -> blinker  0=OFF 1=ON 2=BLINK 3=BURST                  |
// |   cfg_period  host -> blinker  period in ms                                |
// |   cfg_high    host -> blinker  high time in ms                             |
// |   cfg_burst   host -> blinker  number of periods in BURST mode             |
// |   cfg_err     blinker -> host  one-cycle pulse on out-of-range channel     |
// +----------------------------------------------------------------------------+
interface multi_blinker_if #(
  parameter int C_CH_W    = 2,
  parameter int C_PER_W   = 12,
  parameter int C_BURST_W = 8
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [C_CH_W-1:0]    cfg_ch;
  logic [1:0]           cfg_mode;
  logic [C_PER_W-1:0]   cfg_period;
  logic [C_PER_W-1:0]   cfg_high;
  logic [C_BURST_W-1:0] cfg_burst;
  logic                 cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_high, cfg_burst,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_high, cfg_burst,
    output cfg_ready, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/multi_blinker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multi_blinker                                                |
// | Description : Multi-channel runtime-programmable blink/PWM generator.      |
// |               A shared 1 ms prescaler advances a per-channel phase counter;|
// |               each channel is OFF, ON, BLINK (free running) or BURST       |
// |               (B periods, then OFF with a one-cycle done pulse).           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk    in   master clock                                                 |
// |   rst    in   synchronous reset, active-high                               |
// |   sync   in   (MULTI_BLINKER_PHASE_SYNC_EN only) clears prescaler and all  |
// |               BLINK/BURST phases so the LEDs flash in lockstep             |
// |   cfg    if   configuration port (multi_blinker_if.slave)                  |
// |   out    out  per-channel blink outputs, registered                        |
// |   done   out  per-channel one-cycle burst-complete pulse                   |
// | Optional feature macro: MULTI_BLINKER_PHASE_SYNC_EN                        |
// +----------------------------------------------------------------------------+
module multi_blinker #(
  parameter int C_CLK_FRQ    = 100_000_000,
  parameter int C_CHANNELS   = 4,
  parameter int C_PER_W      = 12,
  parameter int C_BURST_W    = 8,
  parameter int C_DEF_PERIOD = 500
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MULTI_BLINKER_PHASE_SYNC_EN
  input  logic                  sync,
`endif
  multi_blinker_if.slave        cfg,
  output logic [C_CHANNELS-1:0] out,
  output logic [C_CHANNELS-1:0] done
);

  localparam int C_DIV   = C_CLK_FRQ / 1000;
  localparam int C_PRE_W = $clog2(C_DIV);
  localparam int C_CH_W  = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;

  // ---------------------------------------------------------------------------
  // Shared 1 ms prescaler and configuration handshake
  // ---------------------------------------------------------------------------
  logic [C_PRE_W-1:0] pre_q, pre_d;
  logic               rdy_q;
  logic               err_q;
  logic               w_tick;
  logic               w_sync;
  logic               w_accept;
  logic               w_bad_ch;

`ifdef MULTI_BLINKER_PHASE_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  assign w_tick   = (pre_q == C_PRE_W'(C_DIV - 1));
  assign w_accept = cfg.cfg_valid && rdy_q;

  // Indices beyond the channel count only exist when the count is not a
  // power of two; otherwise every encodable index is valid.
  if (C_CHANNELS == (2 ** C_CH_W)) begin : g_range_full
    assign w_bad_ch = 1'b0;
  end else begin : g_range_part
    assign w_bad_ch = (cfg.cfg_ch >= C_CH_W'(C_CHANNELS));
  end

  always_comb begin
    pre_d = w_tick ? '0 : pre_q + C_PRE_W'(1);
    if (w_sync) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      rdy_q <= 1'b1;
      err_q <= w_accept && w_bad_ch;
    end
  end

  assign cfg.cfg_ready = rdy_q;
  assign cfg.cfg_err   = err_q;

  // ---------------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < C_CHANNELS; g++) begin : g_ch
    localparam logic [C_CH_W-1:0] C_IDX = C_CH_W'(g);

    mode_t                mode_q, mode_d;
    logic [C_PER_W-1:0]   per_q,  per_d;
    logic [C_PER_W-1:0]   high_q, high_d;
    logic [C_PER_W-1:0]   ph_q,   ph_d;
    logic [C_BURST_W-1:0] burst_q, burst_d;
    logic [C_BURST_W-1:0] bcnt_q,  bcnt_d;
    logic                 out_q,  out_d;
    logic                 done_q, done_d;
    logic                 w_wr;

    assign w_wr = w_accept && (cfg.cfg_ch == C_IDX);

    always_comb begin
      mode_d  = mode_q;
      per_d   = per_q;
      high_d  = high_q;
      burst_d = burst_q;
      ph_d    = ph_q;
      bcnt_d  = bcnt_q;
      done_d  = 1'b0;

      if (w_wr) begin
        // A write always wins over a tick, wrap or sync on this channel and
        // silently aborts any burst in progress.
        mode_d  = mode_t'(cfg.cfg_mode);
        per_d   = (cfg.cfg_period == '0) ? C_PER_W'(1) : cfg.cfg_period;
        high_d  = cfg.cfg_high;
        burst_d = cfg.cfg_burst;
        ph_d    = '0;
        bcnt_d  = '0;
        // A zero-length burst completes immediately.
        if ((mode_t'(cfg.cfg_mode) == MODE_BURST) && (cfg.cfg_burst == '0)) begin
          mode_d = MODE_OFF;
          done_d = 1'b1;
        end
      end else if ((mode_q == MODE_BLINK) || (mode_q == MODE_BURST)) begin
        if (w_sync) begin
          ph_d = '0;
        end else if (w_tick) begin
          if (ph_q == per_q - C_PER_W'(1)) begin
            ph_d = '0;
            if (mode_q == MODE_BURST) begin
              if (bcnt_q == burst_q - C_BURST_W'(1)) begin
                mode_d = MODE_OFF;
                bcnt_d = '0;
                done_d = 1'b1;
              end else begin
                bcnt_d = bcnt_q + C_BURST_W'(1);
              end
            end
          end else begin
            ph_d = ph_q + C_PER_W'(1);
          end
        end
      end

      // Output follows the current state; ph < per always holds, so
      // high >= per yields a constant 1 and high == 0 a constant 0.
      case (mode_q)
        MODE_OFF: out_d = 1'b0;
        MODE_ON:  out_d = 1'b1;
        default:  out_d = (ph_q < high_q);
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        mode_q  <= MODE_OFF;
        per_q   <= C_PER_W'(C_DEF_PERIOD);
        high_q  <= C_PER_W'(C_DEF_PERIOD / 2);
        burst_q <= '0;
        ph_q    <= '0;
        bcnt_q  <= '0;
        out_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        per_q   <= per_d;
        high_q  <= high_d;
        burst_q <= burst_d;
        ph_q    <= ph_d;
        bcnt_q  <= bcnt_d;
        out_q   <= out_d;
        done_q  <= done_d;
      end
    end

    assign out[g]  = out_q;
    assign done[g] = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_blinker.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multi_blinker                                             |
// | Description : Scoreboard bench for multi_blinker. A reference model driven |
// |               by the same inputs pushes the expected outputs of every      |
// |               clock edge into a queue; a monitor pops and compares them    |
// |               half a cycle later. Six channels are used so that channel    |
// |               indices 6 and 7 exercise the out-of-range error path.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multi_blinker;
  localparam int NCH   = 6;
  localparam int CHW   = 3;
  localparam int PW    = 12;
  localparam int BW    = 8;
  localparam int FRQ   = 10_000;
  localparam int DIV   = FRQ / 1000;
  localparam int DEF_P = 500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] out;
  logic [NCH-1:0] done;
  logic sync_in = 1'b0;

  always #5 clk = ~clk;

  multi_blinker_if #(.C_CH_W(CHW), .C_PER_W(PW), .C_BURST_W(BW)) cfg_bus ();

  multi_blinker #(
    .C_CLK_FRQ   (FRQ),
    .C_CHANNELS  (NCH),
    .C_PER_W     (PW),
    .C_BURST_W   (BW),
    .C_DEF_PERIOD(DEF_P)
  ) dut (
    .clk (clk),
    .rst (rst),
`ifdef MULTI_BLINKER_PHASE_SYNC_EN
    .sync(sync_in),
`endif
    .cfg (cfg_bus),
    .out (out),
    .done(done)
  );

  typedef struct packed {
    logic [NCH-1:0] out;
    logic [NCH-1:0] done;
    logic           err;
    logic           rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // ---------------------------------------------------------------------------
  // Reference model: a channel's phase is the number of ms ticks since it was
  // loaded (or last synced) modulo its period; completed bursts are counted
  // as whole periods elapsed.
  // ---------------------------------------------------------------------------
  int m_mode[NCH];
  int m_p[NCH];
  int m_h[NCH];
  int m_b[NCH];
  int m_t[NCH];   // ticks since load / sync
  int m_nb[NCH];  // whole periods completed before the last sync
  int m_pre;      // cycles elapsed in current ms
  bit m_rdy;
  bit m_started = 1'b0;

  function automatic logic model_out(input int c);
    if (m_mode[c] == 0) return 1'b0;
    if (m_mode[c] == 1) return 1'b1;
    return ((m_t[c] % m_p[c]) < m_h[c]);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   tick;
    bit   sy;
    bit   acc;
    int   ch;
    e = '0;
    if (rst) begin
      m_started = 1'b1;
      m_pre = 0;
      m_rdy = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_p[c] = DEF_P; m_h[c] = DEF_P / 2;
        m_b[c] = 0; m_t[c] = 0; m_nb[c] = 0;
      end
      exp_q.push_back(e);
    end else if (m_started) begin
      for (int c = 0; c < NCH; c++) e.out[c] = model_out(c);
      tick = (m_pre == DIV - 1);
`ifdef MULTI_BLINKER_PHASE_SYNC_EN
      sy = sync_in;
`else
      sy = 1'b0;
`endif
      acc = cfg_bus.cfg_valid && m_rdy;
      ch  = int'(cfg_bus.cfg_ch);
      e.err = acc && (ch >= NCH);
      for (int c = 0; c < NCH; c++) begin
        if (acc && ch == c) begin
          m_mode[c] = int'(cfg_bus.cfg_mode);
          m_p[c]    = (cfg_bus.cfg_period == 0) ? 1 : int'(cfg_bus.cfg_period);
          m_h[c]    = int'(cfg_bus.cfg_high);
          m_b[c]    = int'(cfg_bus.cfg_burst);
          m_t[c]    = 0;
          m_nb[c]   = 0;
          if (m_mode[c] == 3 && m_b[c] == 0) begin
            m_mode[c] = 0;
            e.done[c] = 1'b1;
          end
        end else if (m_mode[c] >= 2) begin
          if (sy) begin
            m_nb[c] += m_t[c] / m_p[c];
            m_t[c] = 0;
          end else if (tick) begin
            m_t[c]++;
            if (m_mode[c] == 3 && (m_t[c] % m_p[c]) == 0 &&
                m_nb[c] + m_t[c] / m_p[c] == m_b[c]) begin
              m_mode[c] = 0;
              m_t[c] = 0;
              m_nb[c] = 0;
              e.done[c] = 1'b1;
            end
          end
        end
      end
      m_pre = (sy || tick) ? 0 : m_pre + 1;
      m_rdy = 1'b1;
      e.rdy = 1'b1;
      exp_q.push_back(e);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out",       32'(out),                 32'(e.out));
      chk("done",      32'(done),                32'(e.done));
      chk("cfg_err",   32'(cfg_bus.cfg_err),     32'(e.err));
      chk("cfg_ready", 32'(cfg_bus.cfg_ready),   32'(e.rdy));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus (all changes on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int mode, input int per,
                           input int high, input int burst);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_ch     = CHW'(ch);
    cfg_bus.cfg_mode   = 2'(mode);
    cfg_bus.cfg_period = PW'(per);
    cfg_bus.cfg_high   = PW'(high);
    cfg_bus.cfg_burst  = BW'(burst);
    @(negedge clk);
    cfg_bus.cfg_valid  = 1'b0;
  endtask

  initial begin
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_ch     = '0;
    cfg_bus.cfg_mode   = '0;
    cfg_bus.cfg_period = '0;
    cfg_bus.cfg_high   = '0;
    cfg_bus.cfg_burst  = '0;
    rst = 1'b1;
    sync_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Free-running blink and a three-period burst.
    cfg_write(0, 2, 4, 2, 0);
    idle(100);
    cfg_write(1, 3, 2, 1, 3);
    idle(80);

    // Boundaries: H=0, H>=P, P=0, zero-length burst.
    cfg_write(2, 2, 3, 0, 0);
    cfg_write(3, 2, 3, 5, 0);
    cfg_write(4, 2, 0, 1, 0);
    cfg_write(5, 3, 2, 1, 0);
    idle(30);

    // Override mid-burst, then out-of-range channels.
    cfg_write(1, 3, 3, 2, 4);
    idle(45);
    cfg_write(1, 2, 5, 2, 0);
    idle(60);
    cfg_write(6, 1, 4, 2, 1);
    idle(2);
    cfg_write(7, 3, 2, 1, 2);
    idle(20);
    cfg_write(2, 1, 1, 0, 0);
    cfg_write(3, 0, 1, 0, 0);
    idle(10);

`ifdef MULTI_BLINKER_PHASE_SYNC_EN
    cfg_write(0, 2, 4, 2, 0);
    idle(6);
    cfg_write(1, 2, 4, 2, 0);
    idle(13);
    sync_in = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
    idle(100);
`endif

    // Randomised traffic, with occasional reset (including mid-burst).
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 25));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        idle($urandom_range(1, 3));
        rst = 1'b0;
      end
`ifdef MULTI_BLINKER_PHASE_SYNC_EN
      if ($urandom_range(0, 19) == 0) begin
        sync_in = 1'b1;
        @(negedge clk);
        sync_in = 1'b0;
      end
`endif
      cfg_write($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 6),
                $urandom_range(0, 7), $urandom_range(0, 4));
    end
    idle(60);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
